// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the two-port memory controller: command codes,
// FSM state encoding and a request-decode helper.
package mem_ctrl_pkg;

    localparam logic [1:0] RW_IDLE  = 2'd0;
    localparam logic [1:0] RW_READ  = 2'd1;
    localparam logic [1:0] RW_WRITE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mc_state_e;

    // Only read and write are real commands; 0 and 3 never start an access.
    function automatic logic is_req(input logic [1:0] flag);
        return (flag == RW_READ) || (flag == RW_WRITE);
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the MMU request ports, the byte-wide RAM and mem_ctrl.
// The slave modport is the controller; the master modport is the environment.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 17
);
    logic [3:0]        i_rw_flag;
    logic [63:0]       i_addr;
    logic [63:0]       i_write_data;
    logic [7:0]        i_write_mask;
    logic [63:0]       o_read_data;
    logic [1:0]        o_busy;
    logic [1:0]        o_done;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [7:0]        o_ram_wdata;
    logic              o_ram_we;
    logic [7:0]        i_ram_rdata;

    modport slave (
        input  i_rw_flag, i_addr, i_write_data, i_write_mask, i_ram_rdata,
        output o_read_data, o_busy, o_done, o_ram_addr, o_ram_wdata, o_ram_we
    );

    modport master (
        output i_rw_flag, i_addr, i_write_data, i_write_mask, i_ram_rdata,
        input  o_read_data, o_busy, o_done, o_ram_addr, o_ram_wdata, o_ram_we
    );
endinterface

// File: rtl/mc_rr_arbiter.sv
// Two-requester round-robin arbiter. A tie goes to the port not granted last;
// the last-grant bit resets to 0 so port 1 wins the first tie.
module mc_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant
);

    logic last_q;

    always_comb begin
        grant = 1'b0;
        unique case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_q;
            default: grant = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else if (accept) begin
            last_q <= grant;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Two-port memory controller: round-robin arbitration, each 32-bit access
// serialised into four little-endian byte beats on a 1-cycle-latency RAM.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 17
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_ctrl_if.slave bus
);

    mc_state_e         state_q, state_d;
    logic              port_q, port_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wword_q, wword_d;
    logic [3:0]        mask_q, mask_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [23:0]       rbuf_q, rbuf_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [1:0]        busy_q, busy_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;

    logic [1:0]        pending;
    logic              accept;
    logic              grant;
    logic [1:0]        req_flag;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_mask;
    logic [1:0]        nbeat;

    assign pending[0] = is_req(bus.i_rw_flag[1:0]) && !busy_q[0];
    assign pending[1] = is_req(bus.i_rw_flag[3:2]) && !busy_q[1];
    assign accept     = (state_q == IDLE) && (|pending);

    mc_rr_arbiter u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (pending),
        .accept (accept),
        .grant  (grant)
    );

    assign req_flag  = grant ? bus.i_rw_flag[3:2]       : bus.i_rw_flag[1:0];
    assign req_addr  = grant ? bus.i_addr[32 +: ADDR_W] : bus.i_addr[0 +: ADDR_W];
    assign req_wdata = grant ? bus.i_write_data[63:32]  : bus.i_write_data[31:0];
    assign req_mask  = grant ? bus.i_write_mask[7:4]    : bus.i_write_mask[3:0];
    assign nbeat     = cnt_q[1:0] + 2'd1;

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        write_d     = write_q;
        base_d      = base_q;
        wword_d     = wword_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        rbuf_d      = rbuf_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    port_d         = grant;
                    write_d        = (req_flag == RW_WRITE);
                    base_d         = req_addr;
                    wword_d        = req_wdata;
                    mask_d         = req_mask;
                    cnt_d          = 3'd0;
                    busy_d[grant]  = 1'b1;
                    // Beat 0 is registered at the acceptance edge so it appears in cycle 1.
                    ram_addr_d     = req_addr;
                    if (req_flag == RW_WRITE) begin
                        ram_wdata_d = req_wdata[7:0];
                        ram_we_d    = req_mask[0];
                        state_d     = WRITE;
                    end else begin
                        state_d     = READ;
                    end
                end
            end
            READ: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q < 3'd3) begin
                    ram_addr_d = base_q + ADDR_W'(nbeat);
                end
                // Byte for address beat k arrives while cnt_q == k + 1.
                case (cnt_q)
                    3'd1: rbuf_d[7:0]   = bus.i_ram_rdata;
                    3'd2: rbuf_d[15:8]  = bus.i_ram_rdata;
                    3'd3: rbuf_d[23:16] = bus.i_ram_rdata;
                    3'd4: begin
                        if (port_q) begin
                            rdata_d[63:32] = {bus.i_ram_rdata, rbuf_q};
                        end else begin
                            rdata_d[31:0]  = {bus.i_ram_rdata, rbuf_q};
                        end
                        state_d = DONE;
                    end
                    default: ;
                endcase
            end
            WRITE: begin
                if (cnt_q[1:0] == 2'd3) begin
                    state_d = DONE;
                end else begin
                    cnt_d       = cnt_q + 3'd1;
                    ram_addr_d  = base_q + ADDR_W'(nbeat);
                    ram_wdata_d = wword_q[{nbeat, 3'b000} +: 8];
                    ram_we_d    = mask_q[nbeat];
                end
            end
            DONE: begin
                busy_d[port_q] = 1'b0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            write_q     <= 1'b0;
            base_q      <= '0;
            wword_q     <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            rbuf_q      <= '0;
            rdata_q     <= '0;
            busy_q      <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            write_q     <= write_d;
            base_q      <= base_d;
            wword_q     <= wword_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            rbuf_q      <= rbuf_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
        end
    end

    assign bus.o_read_data = rdata_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = (state_q == DONE) ? {port_q, ~port_q} : 2'b00;
    assign bus.o_ram_addr  = ram_addr_q;
    assign bus.o_ram_wdata = ram_wdata_q;
    assign bus.o_ram_we    = ram_we_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a vector table of single accesses, then
// hand-written sequences for arbitration ties, mid-write reset and flag corner cases.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int unsigned ADDR_W = 17;

    typedef struct {
        int          port;
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          exp_done;
        logic [31:0] exp_rd;
        logic [3:0]  exp_we;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous byte RAM, one cycle read latency.
    bit   [7:0] mem [0:(1 << ADDR_W) - 1];
    logic [7:0] ram_rdata_q = 8'h00;
    always @(posedge clk) begin
        if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_wdata;
        ram_rdata_q <= mem[bus.o_ram_addr];
    end
    assign bus.i_ram_rdata = ram_rdata_q;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd [2];
    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [1:0] rw, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] m);
        if (p == 0) begin
            bus.i_rw_flag[1:0]     = rw;
            bus.i_addr[31:0]       = a;
            bus.i_write_data[31:0] = wd;
            bus.i_write_mask[3:0]  = m;
        end else begin
            bus.i_rw_flag[3:2]      = rw;
            bus.i_addr[63:32]       = a;
            bus.i_write_data[63:32] = wd;
            bus.i_write_mask[7:4]   = m;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_port(0, RW_IDLE, 32'h0, 32'h0, 4'h0);
        set_port(1, RW_IDLE, 32'h0, 32'h0, 4'h0);
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int p, output int cyc);
        cyc = 0;
        for (int c = 1; c <= 12 && cyc == 0; c++) begin
            @(negedge clk);
            if (bus.o_done[p]) cyc = c;
        end
    endtask

    // One access from an idle controller; cycle c is the c-th cycle after acceptance.
    task automatic run_op(input vec_t v, input string tag);
        logic [ADDR_W-1:0] alog [4];
        logic [7:0]        wlog [4];
        logic [3:0]        we_bits;
        logic [ADDR_W-1:0] ea;
        int                done_cyc;
        @(negedge clk);
        set_port(v.port, v.rw, v.addr, v.wdata, v.mask);
        @(posedge clk);
        #1;
        set_port(v.port, RW_IDLE, 32'h0, 32'h0, 4'h0);
        check({tag, "_busy_accept"}, 64'(bus.o_busy[v.port]), 64'd1);
        done_cyc = 0;
        we_bits  = 4'h0;
        for (int c = 1; c <= 12 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                alog[c-1]    = bus.o_ram_addr;
                wlog[c-1]    = bus.o_ram_wdata;
                we_bits[c-1] = bus.o_ram_we;
            end
            if (bus.o_done[v.port]) begin
                done_cyc = c;
                check({tag, "_busy_done"}, 64'(bus.o_busy[v.port]), 64'd1);
                if (v.rw == RW_READ) exp_rd[v.port] = v.exp_rd;
                check({tag, "_rdata"}, 64'(bus.o_read_data[32*v.port +: 32]),
                      64'(exp_rd[v.port]));
                check({tag, "_other_rdata"}, 64'(bus.o_read_data[32*(1-v.port) +: 32]),
                      64'(exp_rd[1-v.port]));
            end
        end
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
        for (int k = 0; k < 4; k++) begin
            ea = v.addr[ADDR_W-1:0] + ADDR_W'(k);
            check($sformatf("%s_addr%0d", tag, k), 64'(alog[k]), 64'(ea));
            if (v.exp_we[k]) begin
                check($sformatf("%s_wdata%0d", tag, k), 64'(wlog[k]), 64'(v.wdata[8*k +: 8]));
            end
        end
        check({tag, "_we_pattern"}, 64'(we_bits), 64'(v.exp_we));
    endtask

    initial begin : main
        int   cyc;
        int   bad;
        int   dones;
        logic [ADDR_W-1:0] a0;
        vec_t v;

        vecs[0] = '{0, RW_WRITE, 32'h0000_0100, 32'h4433_2211, 4'b1111, 5, 32'h0,         4'b1111};
        vecs[1] = '{0, RW_READ,  32'h0000_0100, 32'h0,         4'b0000, 6, 32'h4433_2211, 4'b0000};
        vecs[2] = '{1, RW_WRITE, 32'h0000_0200, 32'hAABB_CCDD, 4'b0101, 5, 32'h0,         4'b0101};
        vecs[3] = '{1, RW_READ,  32'h0000_0200, 32'h0,         4'b0000, 6, 32'h00BB_00DD, 4'b0000};
        vecs[4] = '{1, RW_WRITE, 32'h0001_FFFE, 32'hD4C3_B2A1, 4'b1111, 5, 32'h0,         4'b1111};
        vecs[5] = '{0, RW_READ,  32'h0001_FFFE, 32'h0,         4'b0000, 6, 32'hD4C3_B2A1, 4'b0000};
        vecs[6] = '{1, RW_READ,  32'hABC0_0100, 32'h0,         4'b0000, 6, 32'h4433_2211, 4'b0000};
        vecs[7] = '{0, RW_WRITE, 32'h0000_0300, 32'h1234_5678, 4'b1010, 5, 32'h0,         4'b1010};
        vecs[8] = '{0, RW_READ,  32'h0000_0300, 32'h0,         4'b0000, 6, 32'h1200_5600, 4'b0000};

        do_reset();
        @(negedge clk);
        check("rst_busy",  64'(bus.o_busy),      64'd0);
        check("rst_done",  64'(bus.o_done),      64'd0);
        check("rst_we",    64'(bus.o_ram_we),    64'd0);
        check("rst_rdata", bus.o_read_data,      64'd0);
        check("rst_raddr", 64'(bus.o_ram_addr),  64'd0);
        check("rst_wdata", 64'(bus.o_ram_wdata), 64'd0);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous reads right after reset; both flags held so each retire is a new tie.
        do_reset();
        @(negedge clk);
        set_port(0, RW_READ, 32'h0000_0100, 32'h0, 4'h0);
        set_port(1, RW_READ, 32'h0001_FFFE, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        check("tie1_grant", 64'(bus.o_busy), 64'b10);
        wait_done(1, cyc);
        check("tie1_done_cycle", 64'(cyc), 64'd6);
        check("tie1_rdata", 64'(bus.o_read_data[63:32]), 64'hD4C3_B2A1);
        @(posedge clk);
        #1;
        check("tie_idle_gap", 64'(bus.o_busy), 64'b00);
        @(posedge clk);
        #1;
        check("tie2_grant", 64'(bus.o_busy), 64'b01);
        wait_done(0, cyc);
        check("tie2_done_cycle", 64'(cyc), 64'd6);
        check("tie2_rdata", 64'(bus.o_read_data[31:0]), 64'h4433_2211);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("tie3_grant", 64'(bus.o_busy), 64'b10);
        set_port(0, RW_IDLE, 32'h0, 32'h0, 4'h0);
        set_port(1, RW_IDLE, 32'h0, 32'h0, 4'h0);
        wait_done(1, cyc);
        check("tie3_done_cycle", 64'(cyc), 64'd6);

        // Reset asserted during the third write beat.
        do_reset();
        @(negedge clk);
        set_port(0, RW_WRITE, 32'h0000_0400, 32'h0A0B_0C0D, 4'hF);
        @(posedge clk);
        #1;
        set_port(0, RW_IDLE, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        check("rstmid_beat2_we",   64'(bus.o_ram_we),   64'd1);
        check("rstmid_beat2_addr", 64'(bus.o_ram_addr), 64'h402);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", 64'(bus.o_busy),   64'd0);
        check("rstmid_we",   64'(bus.o_ram_we), 64'd0);
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (bus.o_done != 2'b00) dones++;
        end
        check("rstmid_no_done", 64'(dones), 64'd0);
        check("rstmid_mem400", 64'(mem[17'h400]), 64'h0D);
        check("rstmid_mem401", 64'(mem[17'h401]), 64'h0C);
        check("rstmid_mem402", 64'(mem[17'h402]), 64'h00);
        v = '{0, RW_READ, 32'h0000_0400, 32'h0, 4'b0000, 6, 32'h0000_0C0D, 4'b0000};
        run_op(v, "post_rst_read");

        // Flag 3 must never be accepted.
        @(negedge clk);
        bus.i_rw_flag[1:0] = 2'b11;
        a0  = bus.o_ram_addr;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.o_busy != 2'b00 || bus.o_ram_we || bus.o_ram_addr != a0) bad++;
        end
        check("flag3_ignored", 64'(bad), 64'd0);
        bus.i_rw_flag[1:0] = RW_IDLE;

        // Read flag held through done is re-accepted after the single IDLE cycle.
        @(negedge clk);
        set_port(0, RW_READ, 32'h0000_0100, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        check("hold_busy_accept", 64'(bus.o_busy[0]), 64'd1);
        wait_done(0, cyc);
        check("hold_done_cycle", 64'(cyc), 64'd6);
        @(negedge clk);
        check("hold_idle_cycle", 64'(bus.o_busy[0]), 64'd0);
        @(negedge clk);
        check("hold_reaccept", 64'(bus.o_busy[0]), 64'd1);
        set_port(0, RW_IDLE, 32'h0, 32'h0, 4'h0);
        wait_done(0, cyc);
        check("hold_second_done", 64'(cyc), 64'd5);
        check("hold_second_rdata", 64'(bus.o_read_data[31:0]), 64'h4433_2211);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-controller responder for the two-port request interface driven by the CPU's MMU: port 0 carries instruction fetch, port 1 carries data load/store. It arbitrates between the two ports round-robin and serialises each 32-bit access into four byte beats on a byte-wide synchronous RAM. It returns read words and completion pulses per port.

## Interface
- ADDR_W, 17, byte-address width of the RAM side. Request addresses are truncated to this width.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_rw_flag  in  4  per-port command, {port1[3:2], port0[1:0]}: 0 = idle, 1 = read, 2 = write, 3 = ignored
- i_addr  in  64  per-port byte address, {port1[63:32], port0[31:0]}
- i_write_data  in  64  per-port write word
- i_write_mask  in  8  per-port byte enables; bit k enables byte k = data[8k+7:8k]
- o_read_data  out  64  per-port read word; valid in the done cycle, then held
- o_busy  out  2  per-port "request accepted, not yet retired"
- o_done  out  2  per-port one-cycle completion pulse
- o_ram_addr  out  ADDR_W  RAM byte address
- o_ram_wdata  out  8  RAM write byte
- o_ram_we  out  1  RAM write strobe
- i_ram_rdata  in  8  RAM read byte, valid exactly 1 cycle after its address

## Operation
- Port p is pending when i_rw_flag[p] is 1 or 2 and o_busy[p] = 0.
- IDLE: if any port is pending, the arbiter grants one port. The controller latches that port's flag, address (low ADDR_W bits), data and mask, sets o_busy[p] = 1, and moves to READ or WRITE.
- Arbitration: round-robin with a one-bit last-grant register. When both ports are pending, grant the port not granted last. The register resets so that port 1 wins the first tie.
- READ: beat counter k runs 0..3, and o_ram_addr = base + k (mod 2^ADDR_W). The byte returned one cycle later is stored in word byte k (little-endian). The state lasts 5 cycles (4 address cycles plus the final capture), then goes to DONE.
- WRITE: for 4 cycles, o_ram_addr = base + k and o_ram_wdata = byte k. o_ram_we = mask[k]; masked-off beats still take their cycle. Then DONE.
- DONE: for one cycle, o_done[p] = 1 and, for reads only, o_read_data[p] is updated. o_busy[p] is still 1. Next state is IDLE, where o_busy[p] = 0.
- The other port's o_read_data is never disturbed. A write leaves the port's o_read_data unchanged.
- Flag 3 and flag 0 are never accepted.
- A flag held asserted after done is accepted again as a new request; the requester owns flag deassertion.
- Reset values: FSM IDLE; o_busy, o_done, o_ram_we = 0; o_read_data, o_ram_addr, o_ram_wdata = 0; last-grant favours port 1.
- Reset mid-operation: the access is aborted with no done pulse, and the RAM write strobe drops immediately. Bytes already written stay written.

## Timing
- Acceptance edge = the edge at which IDLE samples a pending request. o_busy[p] rises after that edge.
- Read: 4 address cycles plus 1 capture cycle, then DONE. o_done is high in the 6th cycle after acceptance.
- Write: 4 beat cycles, then DONE. o_done is high in the 5th cycle after acceptance.
- There is at least one IDLE cycle between two accesses. Back-to-back port alternation costs 7 cycles per read and 6 per write.
- o_ram_we is registered; an address/data/we triple is presented together in one cycle.
- i_ram_rdata is sampled exactly one cycle after the matching o_ram_addr. No other RAM latency is supported.

## Structure
- Add to the shared defines include: RW_IDLE = 0, RW_READ = 1, RW_WRITE = 2; state encodings IDLE, READ, WRITE, DONE.
- One sub-module, mc_rr_arbiter: 2-requester round-robin arbiter with a registered last-grant bit, reset-aware. Everything else stays in mem_ctrl.

## Test plan
- Read, port 0, addr 0x100; RAM[0x100..0x103] = 11,22,33,44 -> addresses 0x100..0x103 on consecutive cycles, o_done[0] in the 6th cycle, o_read_data[31:0] = 0x44332211.
- Write, port 1, addr 0x200, data 0xAABBCCDD, mask 0101 -> o_ram_we only at 0x200 (DD) and 0x202 (BB). o_done[1] in the 5th cycle. A following read of 0x200 from a zeroed RAM returns 0x00BB00DD.
- Both ports request a read in the same cycle just after reset -> port 1 is served first, then port 0. A second tie serves port 0 first.
- Read of 0x1FFFE with ADDR_W = 17 -> RAM addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- rst_n low during the 3rd beat of a write -> o_busy/o_ram_we drop at once and no o_done pulse. A subsequent read completes normally.
- Flag 3 held on port 0 for 20 cycles -> o_busy stays 0 and no RAM activity. A read flag held after done -> re-accepted in the cycle after the post-done IDLE cycle.
